// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   Resolves beq/bne in the ID stage. A branch is captured from ID, held until
//   both forwarded operands are final, presented to an external equality
//   comparator through registered operands, and, when taken, handed to IF as
//   a redirect over a valid/ready handshake. The block owns the IF/ID stall
//   and keeps saturating statistics of taken branches and stalled cycles.
//
// Parameters
//   CNT_W           width of the saturating statistics counters
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   br_valid        ID holds a beq/bne this cycle
//   br_ne           1 = bne, 0 = beq
//   br_pc           PC of the branch instruction
//   br_imm          raw 16-bit offset field
//   rs_ready        rs forwarded value is final this cycle
//   rt_ready        rt forwarded value is final this cycle
//   rs_data         forwarded rs value
//   rt_data         forwarded rt value
//   flush           kill any in-flight branch (exception/eret)
//   cmp_a, cmp_b    registered comparator operands
//   cmp_zero        comparator result, 1 = cmp_a == cmp_b
//   stall           freeze IF/ID
//   redirect_valid  redirect_pc is valid
//   redirect_ready  IF accepts the redirect
//   redirect_pc     branch target
//   resolve_done    one-cycle pulse when a branch retires (taken or not)
//   taken_cnt       saturating count of taken branches
//   stall_cnt       saturating count of cycles with stall high
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic             br_ne,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_imm,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             flush,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_zero,
  output logic             stall,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             resolve_done,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CMP,
    S_REDIR
  } state_t;

  state_t      state;
  logic        ne_q;
  logic        both_ready;
  logic        taken;
  logic [31:0] target;

  // Sign-extended word offset relative to the delay-slot PC; wraps mod 2^32.
  always_comb begin
    target = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  end

  always_comb begin
    both_ready = rs_ready & rt_ready;
  end

  // beq is taken on equality, bne on inequality.
  always_comb begin
    taken = cmp_zero ^ ne_q;
  end

  // Combinational so the branch freezes ID in the very cycle it appears.
  always_comb begin
    stall = (state != S_IDLE) | ((state == S_IDLE) & br_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      ne_q           <= 1'b0;
      cmp_a          <= '0;
      cmp_b          <= '0;
      redirect_pc    <= '0;
      redirect_valid <= 1'b0;
      resolve_done   <= 1'b0;
      taken_cnt      <= '0;
      stall_cnt      <= '0;
    end else begin
      resolve_done <= 1'b0;

      // Counts every stalled cycle, including those of a branch being flushed.
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (flush) begin
        state          <= S_IDLE;
        redirect_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (br_valid) begin
              ne_q        <= br_ne;
              redirect_pc <= target;
              if (both_ready) begin
                cmp_a <= rs_data;
                cmp_b <= rt_data;
                state <= S_CMP;
              end else begin
                state <= S_WAIT;
              end
            end
          end

          S_WAIT: begin
            if (both_ready) begin
              cmp_a <= rs_data;
              cmp_b <= rt_data;
              state <= S_CMP;
            end
          end

          S_CMP: begin
            if (taken) begin
              state          <= S_REDIR;
              redirect_valid <= 1'b1;
              if (taken_cnt != '1) begin
                taken_cnt <= taken_cnt + 1'b1;
              end
            end else begin
              state        <= S_IDLE;
              resolve_done <= 1'b1;
            end
          end

          S_REDIR: begin
            if (redirect_ready) begin
              state          <= S_IDLE;
              redirect_valid <= 1'b0;
              resolve_done   <= 1'b1;
            end
          end

          default: begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Directed bench for branch_resolve_ctrl. Two instances share one stimulus:
//   a full-width one (CNT_W=16) and a narrow one (CNT_W=2) whose taken/stall
//   counters saturate early. The comparator is modelled as cmp_a == cmp_b.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        reset;
  logic        br_valid;
  logic        br_ne;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic        rs_ready;
  logic        rt_ready;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        redirect_ready;

  logic [31:0] cmp_a, cmp_b, redirect_pc;
  logic        cmp_zero, stall, redirect_valid, resolve_done;
  logic [15:0] taken_cnt, stall_cnt;

  logic [31:0] s_cmp_a, s_cmp_b, s_redirect_pc;
  logic        s_cmp_zero, s_stall, s_redirect_valid, s_resolve_done;
  logic [1:0]  s_taken_cnt, s_stall_cnt;

  int nvec = 0;
  int nmis = 0;

  assign cmp_zero   = (cmp_a == cmp_b);
  assign s_cmp_zero = (s_cmp_a == s_cmp_b);

  branch_resolve_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ne(br_ne),
    .br_pc(br_pc), .br_imm(br_imm), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_zero(cmp_zero), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .resolve_done(resolve_done),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  branch_resolve_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ne(br_ne),
    .br_pc(br_pc), .br_imm(br_imm), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .cmp_a(s_cmp_a), .cmp_b(s_cmp_b), .cmp_zero(s_cmp_zero), .stall(s_stall),
    .redirect_valid(s_redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(s_redirect_pc), .resolve_done(s_resolve_done),
    .taken_cnt(s_taken_cnt), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a branch in ID with both operands ready.
  task automatic issue(input logic ne, input logic [31:0] pc, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt);
    br_valid = 1'b1;
    br_ne    = ne;
    br_pc    = pc;
    br_imm   = imm;
    rs_data  = rs;
    rt_data  = rt;
    rs_ready = 1'b1;
    rt_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; br_valid = 1'b0; br_ne = 1'b0; br_pc = '0; br_imm = '0;
    rs_ready = 1'b0; rt_ready = 1'b0; rs_data = '0; rt_data = '0;
    flush = 1'b0; redirect_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cmp_a", cmp_a, 32'h0);
    check("rst_cmp_b", cmp_b, 32'h0);
    check("rst_redir_valid", {31'b0, redirect_valid}, 32'h0);
    check("rst_redir_pc", redirect_pc, 32'h0);
    check("rst_done", {31'b0, resolve_done}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_taken_cnt", {16'b0, taken_cnt}, 32'h0);
    check("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    reset = 1'b0;
    tick();

    // 1: beq 5==5 taken, IF ready at once
    issue(1'b0, 32'h0000_1000, 16'h0010, 32'h5, 32'h5);
    redirect_ready = 1'b1;
    #1 check("t1_stall_id", {31'b0, stall}, 32'h1);
    tick();
    br_valid = 1'b0;
    #1;
    check("t1_cmp_a", cmp_a, 32'h5);
    check("t1_cmp_b", cmp_b, 32'h5);
    check("t1_stall_cmp", {31'b0, stall}, 32'h1);
    check("t1_valid_early", {31'b0, redirect_valid}, 32'h0);
    tick();
    check("t1_redir_valid", {31'b0, redirect_valid}, 32'h1);
    check("t1_redir_pc", redirect_pc, 32'h0000_1044);
    check("t1_taken_cnt", {16'b0, taken_cnt}, 32'h1);
    tick();
    check("t1_valid_drop", {31'b0, redirect_valid}, 32'h0);
    check("t1_done", {31'b0, resolve_done}, 32'h1);
    check("t1_stall_idle", {31'b0, stall}, 32'h0);
    check("t1_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    tick();
    check("t1_done_pulse", {31'b0, resolve_done}, 32'h0);

    // 2: bne 5==5 not taken
    issue(1'b1, 32'h0000_2000, 16'h0004, 32'h5, 32'h5);
    tick();
    br_valid = 1'b0;
    tick();
    check("t2_done", {31'b0, resolve_done}, 32'h1);
    check("t2_no_redir", {31'b0, redirect_valid}, 32'h0);
    check("t2_taken_cnt", {16'b0, taken_cnt}, 32'h1);
    check("t2_stall_cnt", {16'b0, stall_cnt}, 32'd5);
    tick();
    check("t2_done_pulse", {31'b0, resolve_done}, 32'h0);

    // 3: beq 0x11 vs rt, rt not ready for 3 cycles -> 3 WAIT cycles, not taken
    issue(1'b0, 32'h0000_4000, 16'h0001, 32'h11, 32'hAA);
    rt_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    tick();
    check("t3_cmp_b_hold", cmp_b, 32'h5);
    tick();
    check("t3_stall_wait", {31'b0, stall}, 32'h1);
    rt_ready = 1'b1;
    rt_data  = 32'h22;
    tick();
    rt_ready = 1'b0;
    rt_data  = 32'hAA;
    check("t3_cmp_a", cmp_a, 32'h11);
    check("t3_cmp_b", cmp_b, 32'h22);
    tick();
    check("t3_done", {31'b0, resolve_done}, 32'h1);
    check("t3_stall_cnt", {16'b0, stall_cnt}, 32'd10);
    tick();

    // 4: taken, target wraps back onto the branch PC, IF busy 4 cycles
    issue(1'b0, 32'h0000_3000, 16'hFFFF, 32'h7, 32'h7);
    redirect_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    tick();
    check("t4_redir_valid", {31'b0, redirect_valid}, 32'h1);
    check("t4_redir_pc", redirect_pc, 32'h0000_3000);
    check("t4_taken_cnt", {16'b0, taken_cnt}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_hold_valid", {31'b0, redirect_valid}, 32'h1);
      check("t4_hold_pc", redirect_pc, 32'h0000_3000);
    end
    redirect_ready = 1'b1;
    tick();
    check("t4_valid_drop", {31'b0, redirect_valid}, 32'h0);
    check("t4_done", {31'b0, resolve_done}, 32'h1);
    check("t4_stall_cnt", {16'b0, stall_cnt}, 32'd17);
    check("t4_s_taken_cnt", {30'b0, s_taken_cnt}, 32'h2);
    tick();

    // 5a: flush while in WAIT
    issue(1'b0, 32'h0000_5000, 16'h0002, 32'h1, 32'h1);
    rt_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("t5a_stall", {31'b0, stall}, 32'h0);
    check("t5a_no_done", {31'b0, resolve_done}, 32'h0);
    tick();
    check("t5a_no_done2", {31'b0, resolve_done}, 32'h0);
    check("t5a_stall_cnt", {16'b0, stall_cnt}, 32'd19);

    // 5b: flush while in REDIR
    issue(1'b0, 32'h0000_6000, 16'h0003, 32'h9, 32'h9);
    redirect_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    tick();
    check("t5b_redir_valid", {31'b0, redirect_valid}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5b_valid_kill", {31'b0, redirect_valid}, 32'h0);
    check("t5b_no_done", {31'b0, resolve_done}, 32'h0);
    tick();
    check("t5b_no_done2", {31'b0, resolve_done}, 32'h0);
    check("t5b_idle", {31'b0, stall}, 32'h0);
    check("t5b_taken_cnt", {16'b0, taken_cnt}, 32'h3);
    check("t5b_stall_cnt", {16'b0, stall_cnt}, 32'd22);

    // 5c: flush together with a new branch in IDLE -> branch dropped
    issue(1'b0, 32'h0000_7000, 16'h0005, 32'h77, 32'h78);
    flush = 1'b1;
    #1 check("t5c_stall", {31'b0, stall}, 32'h1);
    tick();
    br_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("t5c_idle", {31'b0, stall}, 32'h0);
    check("t5c_cmp_a", cmp_a, 32'h9);
    tick();
    check("t5c_no_done", {31'b0, resolve_done}, 32'h0);
    check("t5c_stall_cnt", {16'b0, stall_cnt}, 32'd23);

    // 6: one more taken branch; narrow counters stay saturated
    issue(1'b0, 32'h0000_8000, 16'h0000, 32'h33, 32'h33);
    redirect_ready = 1'b1;
    tick();
    br_valid = 1'b0;
    tick();
    check("t6_redir_pc", redirect_pc, 32'h0000_8004);
    tick();
    check("t6_done", {31'b0, resolve_done}, 32'h1);
    check("t6_taken_cnt", {16'b0, taken_cnt}, 32'h4);
    check("t6_stall_cnt", {16'b0, stall_cnt}, 32'd26);
    check("t6_s_taken_sat", {30'b0, s_taken_cnt}, 32'h3);
    check("t6_s_stall_sat", {30'b0, s_stall_cnt}, 32'h3);
    tick();

    // 7: async reset in the middle of REDIR
    issue(1'b0, 32'h0000_9000, 16'h0008, 32'h4, 32'h4);
    redirect_ready = 1'b0;
    tick();
    br_valid = 1'b0;
    tick();
    check("t7_redir_valid", {31'b0, redirect_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t7_valid", {31'b0, redirect_valid}, 32'h0);
    check("t7_pc", redirect_pc, 32'h0);
    check("t7_cmp_a", cmp_a, 32'h0);
    check("t7_cmp_b", cmp_b, 32'h0);
    check("t7_done", {31'b0, resolve_done}, 32'h0);
    check("t7_stall", {31'b0, stall}, 32'h0);
    check("t7_taken_cnt", {16'b0, taken_cnt}, 32'h0);
    check("t7_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    check("t7_s_taken_cnt", {30'b0, s_taken_cnt}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t7_post_valid", {31'b0, redirect_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
